// File: rtl/traffic_mode_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_mode_ctrl
//
// Supervisory controller for the two-direction traffic-light block. It
// generates the shared 1 s tick and sequences the operating mode: idle
// all-red, normal R/Y/G cycling (run by the light block), all-red clearance,
// night flash and emergency pre-emption. In every mode except NORMAL the light
// block is held disabled and this block supplies the lamp pattern directly.
//
// Parameters
//   TICK_DIV   Clk cycles per 1 s tick (>= 2)
//   ALLRED_S   all-red clearance duration in ticks (1..15)
//
// Ports
//   Clk         in   system clock
//   Rst         in   asynchronous, active-high reset
//   run         in   1 = intersection operating, 0 = idle all-red
//   night       in   night-mode request (level)
//   emg_req     in   emergency pre-emption request (level)
//   emg_dir     in   0 = green to light 1 (NS), 1 = green to light 2 (EW)
//   tick_1s     out  one-Clk pulse every TICK_DIV cycles
//   lights_en   out  enable to the light block
//   ovr_valid   out  1 = output mux shows ovr_lights instead of the light block
//   ovr_lights  out  override pattern {R1,R2,Y1,Y2,G1,G2}
//   mode        out  state code (IDLE=0, NORMAL=1, CLEAR=2, NIGHT=3, EMG=4)
// -----------------------------------------------------------------------------
module traffic_mode_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int ALLRED_S = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       run,
    input  logic       night,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic       tick_1s,
    output logic       lights_en,
    output logic       ovr_valid,
    output logic [5:0] ovr_lights,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NORMAL = 3'd1,
        S_CLEAR  = 3'd2,
        S_NIGHT  = 3'd3,
        S_EMG    = 3'd4
    } state_t;

    typedef struct packed {
        logic       lights_en;
        logic       ovr_valid;
        logic [5:0] ovr_lights;
    } out_t;

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       CLR_LAST = 4'(ALLRED_S - 1);

    // Lamp patterns, bit order {R1,R2,Y1,Y2,G1,G2}
    localparam logic [5:0] LAMP_ALLRED = 6'b110000;
    localparam logic [5:0] LAMP_FLASH  = 6'b001100;
    localparam logic [5:0] LAMP_DARK   = 6'b000000;
    localparam logic [5:0] LAMP_EMG_NS = 6'b010010;
    localparam logic [5:0] LAMP_EMG_EW = 6'b100001;

    // -------------------------------------------------------------------------
    // 1 s tick divider: free-running in every state, never gated by mode.
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_q   <= '0;
            tick_1s <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples the pre-edge values, independent of statement order.
            tick_1s <= (div_q == DIV_LAST);
            div_q   <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Mode sequencing
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    state_t     tgt_q, tgt_d;      // where CLEAR goes when the count expires
    state_t     eff_tgt;           // CLEAR target after this cycle's retargeting
    logic [3:0] cnt_q, cnt_d;      // ticks elapsed in CLEAR
    logic       flash_q, flash_d;  // night flash phase
    logic       dir_q, dir_d;      // emergency direction latched on EMG entry

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        dir_d   = dir_q;
        eff_tgt = tgt_q;

        case (state_q)
            S_IDLE: begin
                if (emg_req) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_EMG;
                end else if (run && night) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_NIGHT;
                end else if (run) begin
                    state_d = S_NORMAL;
                end
            end

            S_NORMAL: begin
                if (emg_req) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_EMG;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else if (night) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_NIGHT;
                end
            end

            S_CLEAR: begin
                // Requests re-aim the clearance without restarting its count.
                if (emg_req) begin
                    eff_tgt = S_EMG;
                end else if (!run) begin
                    eff_tgt = S_IDLE;
                end
                tgt_d = eff_tgt;
                if (tick_1s) begin
                    if (cnt_q == CLR_LAST) begin
                        cnt_d = '0;
                        // A pending night request wins over a plain NORMAL exit.
                        if (eff_tgt == S_NORMAL && night) begin
                            state_d = S_NIGHT;
                        end else begin
                            state_d = eff_tgt;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_NIGHT: begin
                if (emg_req) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_EMG;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else if (!night) begin
                    state_d = S_CLEAR;
                    tgt_d   = S_NORMAL;
                end else if (tick_1s) begin
                    flash_d = ~flash_q;
                end
            end

            S_EMG: begin
                if (!emg_req) begin
                    state_d = S_CLEAR;
                    if (!run) begin
                        tgt_d = S_IDLE;
                    end else if (night) begin
                        tgt_d = S_NIGHT;
                    end else begin
                        tgt_d = S_NORMAL;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Entry actions, shared by every path into the state.
        if (state_d == S_CLEAR && state_q != S_CLEAR) cnt_d   = '0;
        if (state_d == S_NIGHT && state_q != S_NIGHT) flash_d = 1'b1;
        if (state_d == S_EMG   && state_q != S_EMG)   dir_d   = emg_dir;
    end

    // Output decode of a (state, flash, dir) triple; anything unexpected shows
    // all-red with the light block disabled.
    function automatic out_t outs_of(state_t s, logic flash, logic dir);
        out_t o;
        o.lights_en  = 1'b0;
        o.ovr_valid  = 1'b1;
        o.ovr_lights = LAMP_ALLRED;
        case (s)
            S_NORMAL: begin
                o.lights_en = 1'b1;
                o.ovr_valid = 1'b0;
            end
            S_NIGHT: o.ovr_lights = flash ? LAMP_FLASH : LAMP_DARK;
            S_EMG:   o.ovr_lights = dir ? LAMP_EMG_EW : LAMP_EMG_NS;
            default: ;
        endcase
        return o;
    endfunction

    // Outputs are decoded from the next state so they register in step with it.
    out_t outs_d;
    assign outs_d = outs_of(state_d, flash_d, dir_d);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            tgt_q      <= S_NORMAL;
            cnt_q      <= '0;
            flash_q    <= 1'b0;
            dir_q      <= 1'b0;
            lights_en  <= 1'b0;
            ovr_valid  <= 1'b1;
            ovr_lights <= LAMP_ALLRED;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            flash_q    <= flash_d;
            dir_q      <= dir_d;
            lights_en  <= outs_d.lights_en;
            ovr_valid  <= outs_d.ovr_valid;
            ovr_lights <= outs_d.ovr_lights;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_mode_ctrl
//
// Self-checking bench for traffic_mode_ctrl with TICK_DIV=4, ALLRED_S=3.
// A behavioural model tracks elapsed cycles, ticks seen in clearance and ticks
// seen in night mode, and predicts every output after every clock edge.
// Directed scenarios are followed by a randomized input phase.
// -----------------------------------------------------------------------------
module tb_traffic_mode_ctrl;

    localparam int TD = 4;
    localparam int AR = 3;

    localparam int M_IDLE   = 0;
    localparam int M_NORMAL = 1;
    localparam int M_CLEAR  = 2;
    localparam int M_NIGHT  = 3;
    localparam int M_EMG    = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       run, night, emg_req, emg_dir;
    logic       tick_1s, lights_en, ovr_valid;
    logic [5:0] ovr_lights;
    logic [2:0] mode;

    always #5 Clk = ~Clk;

    traffic_mode_ctrl #(.TICK_DIV(TD), .ALLRED_S(AR)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .run       (run),
        .night     (night),
        .emg_req   (emg_req),
        .emg_dir   (emg_dir),
        .tick_1s   (tick_1s),
        .lights_en (lights_en),
        .ovr_valid (ovr_valid),
        .ovr_lights(ovr_lights),
        .mode      (mode)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d (0b%06b) expected=%0d (0b%06b) at t=%0t",
                     tag, got, got[5:0], exp, exp[5:0], $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int cyc;        // clock edges since reset release
    bit m_tick;     // predicted tick_1s after the latest edge
    int m_mode;
    int m_tgt;
    int m_cnt;      // ticks seen since entering CLEAR
    int m_nticks;   // ticks seen since entering NIGHT
    bit m_dir;

    task automatic model_reset();
        cyc      = 0;
        m_tick   = 1'b0;
        m_mode   = M_IDLE;
        m_tgt    = M_NORMAL;
        m_cnt    = 0;
        m_nticks = 0;
        m_dir    = 1'b0;
    endtask

    task automatic go(input int m);
        if (m == M_EMG && m_mode != M_EMG) m_dir = emg_dir;
        if (m == M_NIGHT && m_mode != M_NIGHT) m_nticks = 0;
        if (m == M_CLEAR && m_mode != M_CLEAR) m_cnt = 0;
        m_mode = m;
    endtask

    task automatic go_clear(input int t);
        go(M_CLEAR);
        m_tgt = t;
    endtask

    // Advance the model across one clock edge using the inputs held at it.
    task automatic model_edge();
        bit tick_seen;
        int t;
        tick_seen = m_tick;
        cyc++;
        m_tick = (cyc % TD == 0);
        case (m_mode)
            M_IDLE: begin
                if (emg_req)             go_clear(M_EMG);
                else if (run && night)   go_clear(M_NIGHT);
                else if (run)            go(M_NORMAL);
            end
            M_NORMAL: begin
                if (emg_req)             go_clear(M_EMG);
                else if (!run)           go(M_IDLE);
                else if (night)          go_clear(M_NIGHT);
            end
            M_CLEAR: begin
                t = emg_req ? M_EMG : (!run ? M_IDLE : m_tgt);
                m_tgt = t;
                if (tick_seen) begin
                    m_cnt++;
                    if (m_cnt == AR) go((t == M_NORMAL && night) ? M_NIGHT : t);
                end
            end
            M_NIGHT: begin
                if (emg_req)             go_clear(M_EMG);
                else if (!run)           go(M_IDLE);
                else if (!night)         go_clear(M_NORMAL);
                else if (tick_seen)      m_nticks++;
            end
            M_EMG: begin
                if (!emg_req) go_clear(!run ? M_IDLE : (night ? M_NIGHT : M_NORMAL));
            end
            default: go(M_IDLE);
        endcase
    endtask

    function automatic int exp_lamps();
        case (m_mode)
            M_NIGHT: return (m_nticks % 2 == 0) ? 6'b001100 : 6'b000000;
            M_EMG:   return m_dir ? 6'b100001 : 6'b010010;
            default: return 6'b110000;
        endcase
    endfunction

    task automatic check_outputs();
        check_eq("tick_1s",    int'(tick_1s),    int'(m_tick));
        check_eq("mode",       int'(mode),       m_mode);
        check_eq("lights_en",  int'(lights_en),  (m_mode == M_NORMAL) ? 1 : 0);
        check_eq("ovr_valid",  int'(ovr_valid),  (m_mode == M_NORMAL) ? 0 : 1);
        check_eq("ovr_lights", int'(ovr_lights), exp_lamps());
    endtask

    int dut_ticks;

    // Drive inputs, cross one edge, then compare away from the edge.
    task automatic step(input bit r, input bit n, input bit e, input bit d);
        run     = r;
        night   = n;
        emg_req = e;
        emg_dir = d;
        @(posedge Clk);
        model_edge();
        #1;
        if (tick_1s) dut_ticks++;
        check_outputs();
    endtask

    // Hold inputs until the model reaches a mode (bounded), then confirm the DUT.
    task automatic run_until(input bit r, input bit n, input bit e, input bit d,
                             input int want, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && m_mode != want; i++) step(r, n, e, d);
        check_eq(tag, int'(mode), want);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tick"},   int'(tick_1s),    0);
        check_eq({tag, "_mode"},   int'(mode),       M_IDLE);
        check_eq({tag, "_en"},     int'(lights_en),  0);
        check_eq({tag, "_valid"},  int'(ovr_valid),  1);
        check_eq({tag, "_lights"}, int'(ovr_lights), 6'b110000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_tick;
        bit r, n, e, d;

        Rst = 1'b1; run = 1'b0; night = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values("reset");
        Rst = 1'b0;
        model_reset();
        dut_ticks = 0;

        // Idle for 20 cycles: ticks at 4, 8, 12, 16, 20.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check_eq("ticks_in_20_cycles", dut_ticks, 5);

        // run toggles IDLE <-> NORMAL one Clk after the input changes.
        step(1, 0, 0, 0);
        check_eq("run_to_normal", int'(mode), M_NORMAL);
        step(0, 0, 0, 0);
        check_eq("stop_to_idle", int'(mode), M_IDLE);

        // NORMAL -> night (via 3-tick clearance), flash a while, back to NORMAL.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        run_until(1, 1, 0, 0, M_NIGHT, 40, "enter_night");
        for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
        run_until(1, 0, 0, 0, M_NORMAL, 40, "night_to_normal");

        // Emergency towards EW; emg_dir changes inside EMG are ignored.
        run_until(1, 0, 1, 1, M_EMG, 40, "enter_emg_ew");
        check_eq("emg_ew_lights", int'(ovr_lights), 6'b100001);
        for (int i = 0; i < 6; i++) step(1, 0, 1, i[0]);
        check_eq("emg_dir_ignored", int'(ovr_lights), 6'b100001);
        run_until(1, 0, 0, 0, M_NORMAL, 40, "emg_release_normal");

        // Clearance from NIGHT to NORMAL interrupted by emergency + run=0.
        run_until(1, 1, 0, 0, M_NIGHT, 40, "night_again");
        step(1, 1, 0, 0);
        for (int i = 0; i < 40 && !(m_mode == M_CLEAR && m_cnt == 1); i++) step(1, 0, 0, 0);
        check_eq("clear_mid_count", int'(mode), M_CLEAR);
        run_until(0, 0, 1, 0, M_EMG, 40, "retarget_emg");
        check_eq("emg_ns_lights", int'(ovr_lights), 6'b010010);

        // Reset in EMG: outputs return immediately, divider restarts.
        step(0, 0, 1, 0);
        Rst = 1'b1;
        #2;
        check_reset_values("rst_in_emg");
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        dut_ticks  = 0;
        first_tick = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 0);
            if (tick_1s && first_tick == 0) first_tick = i;
        end
        check_eq("first_tick_after_rst", first_tick, 4);

        // Randomized phase: inputs held for random stretches.
        r = 1'b1; n = 1'b0; e = 1'b0; d = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) r = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) n = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) e = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 5) == 0)  d = $urandom_range(0, 1) == 1;
            step(r, n, e, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
